spart_tx: RTL and testbench

SPART_TX -- requirements
Module: spart_tx

---
 rtl/spart_pkg.sv | 23 ++
 rtl/spart_tx.sv | 117 +++++++++++
 tb/tb_spart_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared SPART constants and state encoding, used by both transmitter and receiver.
package spart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } spart_state_e;

  // Even parity over one data byte: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered (holding + shift register) 8N1 serializer
// driven by a 16x oversampling Baud tick. Define SPART_TX_PARITY_EN to insert
// an even-parity bit between the last data bit and the stop bit.
module spart_tx
  import spart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Baud,
  input  logic [DATA_BITS-1:0] TxD_data,
  input  logic                 load,
  output logic                 TxD,
  output logic                 TBR
);

  spart_state_e         state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q;
`ifdef SPART_TX_PARITY_EN
  logic                 par_q;
`endif

  // Last Baud tick of the current bit period.
  logic bit_end_c;
  assign bit_end_c = Baud && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

  // Holding register, frame FSM, tick/bit counters and registered line driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      hold_q   <= '0;
      shift_q  <= '0;
      TxD      <= IDLE_LEVEL;
      TBR      <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      // Accept a new byte only while the holding register is empty; during a
      // transfer cycle TBR is still low, so a coincident load is dropped.
      if (load && TBR) begin
        hold_q <= TxD_data;
        TBR    <= 1'b0;
      end

      if (state == ST_IDLE) tick_cnt <= '0;
      else if (Baud)        tick_cnt <= tick_cnt + TICK_W'(1);

      case (state)
        ST_IDLE: begin
          if (!TBR) begin
            state   <= ST_START;
            shift_q <= hold_q;
            TBR     <= 1'b1;
`ifdef SPART_TX_PARITY_EN
            par_q   <= even_parity(hold_q);
`endif
          end
        end
        ST_START: begin
          if (bit_end_c) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end_c) begin
            shift_q <= shift_q >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef SPART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef SPART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_c) state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (bit_end_c) begin
            if (!TBR) begin
              state   <= ST_START;
              shift_q <= hold_q;
              TBR     <= 1'b1;
`ifdef SPART_TX_PARITY_EN
              par_q   <= even_parity(hold_q);
`endif
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Line level follows the state one cycle later.
      case (state)
        ST_START:  TxD <= 1'b0;
        ST_DATA:   TxD <= shift_q[0];
`ifdef SPART_TX_PARITY_EN
        ST_PARITY: TxD <= par_q;
`endif
        default:   TxD <= IDLE_LEVEL;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: frame timing, double buffering, dropped loads,
// slow Baud and asynchronous reset. Honours SPART_TX_PARITY_EN.
module tb_spart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Baud = 1'b1;
  logic [7:0] TxD_data = 8'h00;
  logic       load = 1'b0;
  logic       TxD;
  logic       TBR;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int div     = 1;

`ifdef SPART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  spart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .Baud     (Baud),
    .TxD_data (TxD_data),
    .load     (load),
    .TxD      (TxD),
    .TBR      (TBR)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one clock; sample point is 1 time unit after the edge. Baud for
  // the next edge is a tick every div cycles.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    Baud = (div == 1) ? 1'b1 : ((cyc % div) == 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    load     = 1'b1;
    TxD_data = d;
    step();
    load     = 1'b0;
  endtask

  // Wait (bounded) for TxD to go low; returns number of steps taken.
  task automatic wait_low(input string tag, input int budget, output int w);
    w = 0;
    while (TxD !== 1'b0 && w < budget) begin
      step();
      w++;
    end
    check(tag, 32'(TxD), 32'd0);
  endtask

  // Check one whole frame of byte d with bc cycles per bit, starting at the
  // current sample, which is low-bit cycle index skip. Counts TBR-high samples.
  task automatic check_frame(input string tag, input logic [7:0] d, input int bc,
                             input int skip, output int tbr_hi);
    logic lv [0:10];
    int   bad;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = d[i];
    lv[9]  = ^d;
    lv[NBITS-1] = 1'b1;
    tbr_hi = 0;
    for (int b = 0; b < NBITS; b++) begin
      bad = 0;
      for (int c = (b == 0) ? skip : 0; c < bc; c++) begin
        if (TxD !== lv[b]) bad++;
        if (TBR === 1'b1) tbr_hi++;
        step();
      end
      check($sformatf("%s_bit%0d_wrong_cycles", tag, b), 32'(bad), 32'd0);
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (TxD !== 1'b1 || TBR !== 1'b1) bad++;
      step();
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int w;
    int th;

    // Reset
    #1 rst = 1'b1;
    step();
    step();
    check("rst_txd", 32'(TxD), 32'd1);
    check("rst_tbr", 32'(TBR), 32'd1);
    rst = 1'b0;
    expect_idle("idle_after_rst", 5);

    // 0x55 with continuous Baud: latency and full 160-cycle frame
    send(8'h55);
    check("55_tbr_after_load", 32'(TBR), 32'd0);
    step();
    check("55_tbr_at_start", 32'(TBR), 32'd1);
    check("55_txd_still_high", 32'(TxD), 32'd1);
    step();
    check("55_txd_low", 32'(TxD), 32'd0);
    check_frame("f55", 8'h55, 16, 0, th);
    check("55_tbr_high_cycles", 32'(th), 32'(NBITS * 16));
    expect_idle("55_idle", 20);

    // 0xA3 then 0x3C as soon as TBR rises: back-to-back frames
    send(8'hA3);
    check("a3_tbr_after_load", 32'(TBR), 32'd0);
    step();
    check("a3_tbr_at_start", 32'(TBR), 32'd1);
    send(8'h3C);
    check("3c_tbr_after_load", 32'(TBR), 32'd0);
    check("a3_txd_low", 32'(TxD), 32'd0);
    check_frame("fa3", 8'hA3, 16, 0, th);
    check("a3_tbr_high_cycles", 32'(th), 32'd1);
    check("b2b_no_gap", 32'(TxD), 32'd0);
    check_frame("f3c", 8'h3C, 16, 0, th);
    check("3c_tbr_high_cycles", 32'(th), 32'(NBITS * 16));
    expect_idle("3c_idle", 20);

    // 0x11, load on transfer cycle (0xEE, dropped), 0x22, then 0x33 while full
    load     = 1'b1;
    TxD_data = 8'h11;
    step();
    check("11_tbr_after_load", 32'(TBR), 32'd0);
    TxD_data = 8'hEE;
    step();
    check("ee_tbr_transfer", 32'(TBR), 32'd1);
    TxD_data = 8'h22;
    step();
    check("22_tbr_after_load", 32'(TBR), 32'd0);
    check("11_txd_low", 32'(TxD), 32'd0);
    TxD_data = 8'h33;
    step();
    load = 1'b0;
    check("33_ignored_tbr", 32'(TBR), 32'd0);
    check_frame("f11", 8'h11, 16, 1, th);
    check("11_tbr_high_cycles", 32'(th), 32'd1);
    check_frame("f22", 8'h22, 16, 0, th);
    check("22_tbr_high_cycles", 32'(th), 32'(NBITS * 16));
    expect_idle("no_33_frame", 200);

    // 0xFF with Baud one cycle in four: 64 cycles per bit
    div = 4;
    while ((cyc % 4) != 3) step();
    send(8'hFF);
    check("ff_tbr_after_load", 32'(TBR), 32'd0);
    wait_low("ff_start", 10, w);
    check("ff_latency", 32'(w), 32'd2);
    check_frame("fff", 8'hFF, 64, 0, th);
    check("ff_frame_cycles", 32'(th), 32'(NBITS * 64));
    expect_idle("ff_idle", 100);
    div = 1;
    step();

    // Reset during data bit 3 of 0x0F with a second byte pending
    send(8'h0F);
    wait_low("0f_start", 10, w);
    check("0f_latency", 32'(w), 32'd2);
    repeat (10) step();
    send(8'h5A);
    repeat (59) step();
    check("0f_bit3_level", 32'(TxD), 32'd1);
    check("0f_tbr_full", 32'(TBR), 32'd0);
    rst = 1'b1;
    #2;
    check("rst_mid_txd", 32'(TxD), 32'd1);
    check("rst_mid_tbr", 32'(TBR), 32'd1);
    step();
    rst = 1'b0;
    expect_idle("after_rst_idle", 300);

    // Reset during the start bit: TxD must rise without a clock edge
    send(8'h0F);
    wait_low("0f2_start", 10, w);
    repeat (5) step();
    check("0f2_start_low", 32'(TxD), 32'd0);
    rst = 1'b1;
    #2;
    check("rst_start_txd", 32'(TxD), 32'd1);
    step();
    rst = 1'b0;
    expect_idle("after_rst2_idle", 200);

    // 0x07 (odd popcount) and 0x03 (even popcount)
    send(8'h07);
    wait_low("07_start", 10, w);
    check_frame("f07", 8'h07, 16, 0, th);
    expect_idle("07_idle", 5);
    send(8'h03);
    wait_low("03_start", 10, w);
    check_frame("f03", 8'h03, 16, 0, th);
    expect_idle("03_idle", 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
